data_mem_ctrl: RTL and testbench

- Data-memory stage for the openmips_min_sopc load/store path.
- Sits directly downstream of the MEM stage and upstream of MEM/WB; exercised by the load-relative programs.
- Holds a synchronous word RAM and executes byte/half/word loads and stores, big-endian.
- Returns sign/zero-extended load results with fixed 1-cycle latency, including same-word store-to-load bypass and misalignment flagging.

---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: synchronous big-endian word RAM with byte/half/word loads and stores,
// 1-cycle load latency, same-word store-to-load bypass and misalignment flagging.
module data_mem_ctrl #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_wd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_wd,
  output logic        rsp_wreg,
  output logic [1:0]  rsp_exc
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic              w_legal;
  logic              w_aligned;
  logic              w_ok;
  logic              w_acc;
  logic              w_wr;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;
  logic              w_unused;

  assign w_idx    = req_addr[ADDR_W+1:2];
  assign w_lane   = req_addr[1:0];
  assign w_unused = ^req_addr[31:ADDR_W+2];
  assign w_acc    = req_valid & ~stall_i;
  assign w_ok     = w_legal & w_aligned;
  assign w_wr     = w_acc & req_we & w_ok;

  // be[3] is the most significant lane (address offset 0, big-endian)
  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wword   = req_wdata;
    case (req_op[1:0])
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b1000 >> w_lane;
        w_wword   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_aligned = ~req_addr[0];
        w_be      = req_addr[1] ? 4'b0011 : 4'b1100;
        w_wword   = {2{req_wdata[15:0]}};
      end
      2'b11: begin
        w_aligned = (w_lane == 2'b00);
        w_be      = 4'b1111;
        w_wword   = req_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (req_op)
      3'b000, 3'b001, 3'b011: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  logic [31:0] r_rd_word;

  // Read is read-first; a store on the edge where reset asserts is suppressed.
  always_ff @(posedge clk) begin
    if (w_wr && reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wword[i*8 +: 8];
      end
    end
    if (w_acc && !req_we) r_rd_word <= r_mem[w_idx];
  end

  logic              r_byp_valid;
  logic [ADDR_W-1:0] r_byp_idx;
  logic [3:0]        r_byp_be;
  logic [31:0]       r_byp_wword;
  logic              r_hit;
  logic              r_ld_ok;
  logic [1:0]        r_lane;
  logic [2:0]        r_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid   <= 1'b0;
      rsp_wd      <= '0;
      rsp_wreg    <= 1'b0;
      rsp_exc     <= 2'b00;
      r_byp_valid <= 1'b0;
      r_byp_idx   <= '0;
      r_byp_be    <= '0;
      r_byp_wword <= '0;
      r_hit       <= 1'b0;
      r_ld_ok     <= 1'b0;
      r_lane      <= '0;
      r_op        <= '0;
    end else if (!stall_i) begin
      rsp_valid   <= req_valid;
      rsp_wreg    <= req_valid & ~req_we & w_ok;
      rsp_exc     <= (!req_valid || w_ok) ? 2'b00 : (req_we ? 2'b10 : 2'b01);
      r_byp_valid <= w_wr;
      if (req_valid) begin
        rsp_wd  <= req_wd;
        r_ld_ok <= ~req_we & w_ok;
        r_lane  <= w_lane;
        r_op    <= req_op;
        r_hit   <= r_byp_valid && (r_byp_idx == w_idx);
      end
      if (w_wr) begin
        r_byp_idx   <= w_idx;
        r_byp_be    <= w_be;
        r_byp_wword <= w_wword;
      end
    end
  end

  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  always_comb begin
    w_word = r_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (r_hit && r_byp_be[i]) w_word[i*8 +: 8] = r_byp_wword[i*8 +: 8];
    end
    case (r_lane)
      2'b00:   w_byte = w_word[31:24];
      2'b01:   w_byte = w_word[23:16];
      2'b10:   w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
    w_half = r_lane[1] ? w_word[15:0] : w_word[31:16];
    case (r_op[1:0])
      2'b00:   w_ext = {{24{~r_op[2] & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_op[2] & w_half[15]}}, w_half};
      2'b11:   w_ext = w_word;
      default: w_ext = '0;
    endcase
    rsp_rdata = r_ld_ok ? w_ext : 32'h0;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, stall/reset sequences, and randomized
// traffic checked against a byte-addressed big-endian memory model.
module tb_data_mem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_wd;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_wd;
  logic        rsp_wreg;
  logic [1:0]  rsp_exc;

  data_mem_ctrl #(.ADDR_W(10), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_wd(rsp_wd),
    .rsp_wreg(rsp_wreg), .rsp_exc(rsp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wd);
    req_valid = v; stall_i = s; req_we = we; req_op = op;
    req_addr = addr; req_wdata = wdata; req_wd = wd;
  endtask

  // Reference: 4 KiB byte array, byte 4*w+k is big-endian byte k of word w
  logic [7:0] bmem [4096];

  function automatic void model_access(input logic we, input logic [2:0] op,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic ok, output logic [31:0] data);
    int size;
    logic legal;
    logic [31:0] tmp;
    int base;
    case (op[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b11:   size = 4;
      default: size = 0;
    endcase
    if (we) legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b011);
    else    legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b011) ||
                    (op == 3'b100) || (op == 3'b101);
    ok   = legal && (size != 0) && ((int'(addr[1:0]) % size) == 0);
    base = int'(addr[11:0]);
    data = 32'h0;
    if (ok && we) begin
      for (int b = 0; b < size; b++) begin
        tmp = wdata >> (8 * (size - 1 - b));
        bmem[base + b] = tmp[7:0];
      end
    end else if (ok) begin
      for (int b = 0; b < size; b++) data = (data << 8) | {24'h0, bmem[base + b]};
      if (!op[2] && size == 1 && data[7])  data = data | 32'hFFFF_FF00;
      if (!op[2] && size == 2 && data[15]) data = data | 32'hFFFF_0000;
    end
  endfunction

  logic        e_valid = 1'b0;
  logic        e_wreg = 1'b0;
  logic [31:0] e_rdata = 32'h0;
  logic [4:0]  e_wd = 5'd0;
  logic [1:0]  e_exc = 2'b00;
  logic        e_exc_known = 1'b0;

  task automatic step_rand(input logic v, input logic s, input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wd);
    logic ok;
    logic [31:0] data;
    drive(v, s, we, op, addr, wdata, wd);
    if (!s) begin
      if (!v) begin
        e_valid = 1'b0; e_wreg = 1'b0; e_exc_known = 1'b0;
      end else begin
        model_access(we, op, addr, wdata, ok, data);
        e_valid = 1'b1;
        e_wreg  = !we && ok;
        e_exc   = ok ? 2'b00 : (we ? 2'b10 : 2'b01);
        e_rdata = (!we && ok) ? data : 32'h0;
        e_wd    = wd;
        e_exc_known = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("rand_valid", {31'h0, rsp_valid}, {31'h0, e_valid});
    chk("rand_wreg", {31'h0, rsp_wreg}, {31'h0, e_wreg});
    chk("rand_rdata", rsp_rdata, e_rdata);
    if (e_exc_known) chk("rand_exc", {30'h0, rsp_exc}, {30'h0, e_exc});
    if (e_wreg) chk("rand_wd", {27'h0, rsp_wd}, {27'h0, e_wd});
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic [31:0] e_rdata;
    logic        e_wreg;
    logic [1:0]  e_exc;
  } vec_t;

  vec_t tbl[18];

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] rd,
                         input logic [4:0] wd, input logic wr, input logic [1:0] ex);
    chk({tag, "_valid"}, {31'h0, rsp_valid}, {31'h0, v});
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk({tag, "_wd"}, {27'h0, rsp_wd}, {27'h0, wd});
    chk({tag, "_wreg"}, {31'h0, rsp_wreg}, {31'h0, wr});
    chk({tag, "_exc"}, {30'h0, rsp_exc}, {30'h0, ex});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'b011, 32'h10,   32'h8A7F1234, 5'd0,  32'h0,        1'b0, 2'b00};
    tbl[1]  = '{1'b0, 3'b011, 32'h10,   32'h0,        5'd5,  32'h8A7F1234, 1'b1, 2'b00};
    tbl[2]  = '{1'b0, 3'b000, 32'h10,   32'h0,        5'd6,  32'hFFFFFF8A, 1'b1, 2'b00};
    tbl[3]  = '{1'b0, 3'b100, 32'h10,   32'h0,        5'd7,  32'h0000008A, 1'b1, 2'b00};
    tbl[4]  = '{1'b0, 3'b000, 32'h11,   32'h0,        5'd8,  32'h0000007F, 1'b1, 2'b00};
    tbl[5]  = '{1'b0, 3'b001, 32'h12,   32'h0,        5'd9,  32'h00001234, 1'b1, 2'b00};
    tbl[6]  = '{1'b0, 3'b101, 32'h10,   32'h0,        5'd10, 32'h00008A7F, 1'b1, 2'b00};
    tbl[7]  = '{1'b1, 3'b000, 32'h13,   32'hAAAA0055, 5'd0,  32'h0,        1'b0, 2'b00};
    tbl[8]  = '{1'b1, 3'b001, 32'h10,   32'h1234BEEF, 5'd0,  32'h0,        1'b0, 2'b00};
    tbl[9]  = '{1'b0, 3'b011, 32'h10,   32'h0,        5'd11, 32'hBEEF1255, 1'b1, 2'b00};
    tbl[10] = '{1'b0, 3'b011, 32'h12,   32'h0,        5'd12, 32'h0,        1'b0, 2'b01};
    tbl[11] = '{1'b1, 3'b001, 32'h11,   32'h00007777, 5'd0,  32'h0,        1'b0, 2'b10};
    tbl[12] = '{1'b0, 3'b011, 32'h10,   32'h0,        5'd13, 32'hBEEF1255, 1'b1, 2'b00};
    tbl[13] = '{1'b0, 3'b011, 32'h1010, 32'h0,        5'd14, 32'hBEEF1255, 1'b1, 2'b00};
    tbl[14] = '{1'b0, 3'b010, 32'h10,   32'h0,        5'd15, 32'h0,        1'b0, 2'b01};
    tbl[15] = '{1'b1, 3'b100, 32'h10,   32'h00000066, 5'd0,  32'h0,        1'b0, 2'b10};
    tbl[16] = '{1'b0, 3'b001, 32'h13,   32'h0,        5'd16, 32'h0,        1'b0, 2'b01};
    tbl[17] = '{1'b0, 3'b000, 32'h13,   32'h0,        5'd17, 32'h00000055, 1'b1, 2'b00};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_rsp("reset", 1'b0, 32'h0, 5'd0, 1'b0, 2'b00);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b0, tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].wd);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_wreg", i), {31'h0, rsp_wreg}, {31'h0, tbl[i].e_wreg});
      chk($sformatf("tbl%0d_exc", i), {30'h0, rsp_exc}, {30'h0, tbl[i].e_exc});
      if (tbl[i].e_wreg) chk($sformatf("tbl%0d_wd", i), {27'h0, rsp_wd}, {27'h0, tbl[i].wd});
    end

    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("idle_valid", {31'h0, rsp_valid}, 32'h0);
    chk("idle_wreg", {31'h0, rsp_wreg}, 32'h0);
    chk("idle_rdata_hold", rsp_rdata, 32'h00000055);

    drive(1'b1, 1'b0, 1'b0, 3'b011, 32'h10, 32'h0, 5'd7);
    @(posedge clk); #1;
    chk_rsp("stall_lw", 1'b1, 32'hBEEF1255, 5'd7, 1'b1, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_rsp($sformatf("stall_hold%0d", c), 1'b1, 32'hBEEF1255, 5'd7, 1'b1, 2'b00);
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk_rsp("stall_release", 1'b1, 32'h00000055, 5'd9, 1'b1, 2'b00);

    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h20, 32'hCAFEF00D, 5'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("stallsw_valid", {31'h0, rsp_valid}, 32'h1);
    chk("stallsw_wreg", {31'h0, rsp_wreg}, 32'h0);
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk_rsp("stall_wr_rd", 1'b1, 32'hCAFEF00D, 5'd3, 1'b1, 2'b00);

    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h40, 32'h13579BDF, 5'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 3'b011, 32'h40, 32'h0, 5'd21);
    @(posedge clk); #1;
    chk_rsp("pre_reset", 1'b1, 32'h13579BDF, 5'd21, 1'b1, 2'b00);
    #2 reset_n = 1'b0;
    #1;
    chk_rsp("async_reset", 1'b0, 32'h0, 5'd0, 1'b0, 2'b00);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b011, 32'h40, 32'h0, 5'd22);
    @(posedge clk); #1;
    chk_rsp("post_reset", 1'b1, 32'h13579BDF, 5'd22, 1'b1, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 3'b101, 32'h1042, 32'h0, 5'd23);
    @(posedge clk); #1;
    chk_rsp("alias_lhu", 1'b1, 32'h00009BDF, 5'd23, 1'b1, 2'b00);

    for (int w = 0; w < 16; w++) step_rand(1'b1, 1'b0, 1'b1, 3'b011, w * 4, $urandom, 5'd0);
    for (int n = 0; n < 400; n++) begin
      logic v, s, we;
      logic [2:0] op;
      logic [31:0] addr;
      v    = ($urandom_range(0, 99) < 80);
      s    = ($urandom_range(0, 99) < 15);
      we   = ($urandom_range(0, 99) < 40);
      op   = 3'($urandom_range(0, 7));
      addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
             32'($urandom_range(0, 3));
      step_rand(v, s, we, op, addr, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
